// File: rtl/memory_param.sv
// memory_param: parametrised single-clock CPU data/program memory.
// One byte-enabled write port and one read port. The read port is either
// combinational (READ_REG=0) or registered with a one-cycle valid strobe
// (READ_REG=1). After reset, an init sweep writes INIT_WORD into every word.
// Normal traffic is accepted only once the sweep is done and READY is high.
//
// Ports:
//   CLK            clock, all state changes on the rising edge
//   RESET          synchronous active-high reset
//   READY          init sweep complete, accesses accepted
//   WRITE_ENABLE   write request
//   ADDRESS_WRITE  write address
//   DATA_IN        write data
//   BYTE_EN        per-byte write mask (bit i -> DATA_IN[8i+7:8i])
//   RD_EN          read request (registered mode only)
//   ADDRESS_READ   read address
//   DATA_OUT       read data
//   DATA_OUT_VALID read data valid
//   ADDR_ERR       sticky out-of-range access flag
module memory_param #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       READ_REG  = 1,
  parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic                  READY,
  input  logic                  WRITE_ENABLE,
  input  logic [ADDR_W-1:0]     ADDRESS_WRITE,
  input  logic [DATA_W-1:0]     DATA_IN,
  input  logic [DATA_W/8-1:0]   BYTE_EN,
  input  logic                  RD_EN,
  input  logic [ADDR_W-1:0]     ADDRESS_READ,
  output logic [DATA_W-1:0]     DATA_OUT,
  output logic                  DATA_OUT_VALID,
  output logic                  ADDR_ERR
);

  localparam int unsigned       NB       = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_addr_err;

  logic                w_wr_in_range;
  logic                w_rd_in_range;
  logic                w_rd_req;
  logic [DATA_W-1:0]   w_wr_old;
  logic [DATA_W-1:0]   w_wr_merged;
  logic [DATA_W-1:0]   w_rd_word;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  // Range checks; the extra MSB lets DEPTH == 2^ADDR_W compare correctly.
  assign w_wr_in_range = ({1'b0, ADDRESS_WRITE} < DEPTH_L);
  assign w_rd_in_range = ({1'b0, ADDRESS_READ} < DEPTH_L);

  // Array lookups are guarded so an out-of-range index never reaches the array.
  assign w_wr_old  = w_wr_in_range ? r_mem[ADDRESS_WRITE] : '0;
  assign w_rd_word = w_rd_in_range ? r_mem[ADDRESS_READ]  : '0;

  // Byte merge: new bytes where BYTE_EN is set, old bytes elsewhere.
  always_comb begin
    w_wr_merged = w_wr_old;
    for (int i = 0; i < NB; i++) begin
      if (BYTE_EN[i]) begin
        w_wr_merged[8*i +: 8] = DATA_IN[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next state and memory write-port selection (init sweep vs. user write).
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_mem_we     = 1'b0;
    w_mem_addr   = ADDRESS_WRITE;
    w_mem_wdata  = w_wr_merged;
    unique case (r_state)
      ST_INIT: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_idx;
        w_mem_wdata = INIT_WORD;
        if (r_idx == LAST_IDX) begin
          w_state_next = ST_RUN;
        end else begin
          w_idx_next = r_idx + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        w_mem_we = WRITE_ENABLE && w_wr_in_range;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
    // Contents are left untouched on the reset edge itself.
    if (RESET) begin
      w_mem_we = 1'b0;
    end
  end

  assign READY = (r_state == ST_RUN);

  // Storage array (not reset; the init sweep clears it).
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Sticky out-of-range flag, only for requested accesses in RUN.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr_err <= 1'b0;
    end else if ((r_state == ST_RUN) &&
                 ((WRITE_ENABLE && !w_wr_in_range) || (w_rd_req && !w_rd_in_range))) begin
      r_addr_err <= 1'b1;
    end
  end

  assign ADDR_ERR = r_addr_err;

  if (READ_REG != 0) begin : g_rd_reg
    logic [DATA_W-1:0] r_dout;
    logic              r_valid;
    logic              w_wr_hit;

    assign w_rd_req = RD_EN;

    // Same-edge write to the read address: return the merged word (write-first).
    assign w_wr_hit = WRITE_ENABLE && w_wr_in_range && (ADDRESS_WRITE == ADDRESS_READ);

    // Registered read; data holds when no read is issued.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_dout  <= '0;
        r_valid <= 1'b0;
      end else if ((r_state == ST_RUN) && RD_EN) begin
        r_valid <= 1'b1;
        if (!w_rd_in_range) begin
          r_dout <= '0;
        end else if (w_wr_hit) begin
          r_dout <= w_wr_merged;
        end else begin
          r_dout <= w_rd_word;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end

    assign DATA_OUT       = r_dout;
    assign DATA_OUT_VALID = r_valid;
  end else begin : g_rd_comb
    logic w_unused_rd_en;

    // Combinational read: every address presented while READY counts as a read.
    assign w_rd_req       = 1'b1;
    assign w_unused_rd_en = RD_EN;
    assign DATA_OUT       = w_rd_word;
    assign DATA_OUT_VALID = READY;
  end

endmodule

// File: tb/tb_memory_param.sv
// tb_memory_param: directed self-checking bench for memory_param.
// Instance a: DEPTH=256, registered read, INIT_WORD=0.
// Instance b: DEPTH=200, registered read, INIT_WORD=DEADBEEF (out-of-range cases).
// Instance c: DEPTH=12, ADDR_W=4, combinational read, INIT_WORD=0.
module tb_memory_param;

  logic clk;

  logic        a_rst, a_we, a_rd, a_ready, a_valid, a_err;
  logic [7:0]  a_wa, a_ra;
  logic [31:0] a_din, a_dout;
  logic [3:0]  a_be;

  logic        b_rst, b_we, b_rd, b_ready, b_valid, b_err;
  logic [7:0]  b_wa, b_ra;
  logic [31:0] b_din, b_dout;
  logic [3:0]  b_be;

  logic        c_rst, c_we, c_rd, c_ready, c_valid, c_err;
  logic [3:0]  c_wa, c_ra;
  logic [31:0] c_din, c_dout;
  logic [3:0]  c_be;

  int n_checks = 0;
  int n_errors = 0;

  memory_param #(.DATA_W(32), .DEPTH(256), .ADDR_W(8), .READ_REG(1), .INIT_WORD(32'h0)) u_dut_a (
    .CLK(clk), .RESET(a_rst), .READY(a_ready), .WRITE_ENABLE(a_we), .ADDRESS_WRITE(a_wa),
    .DATA_IN(a_din), .BYTE_EN(a_be), .RD_EN(a_rd), .ADDRESS_READ(a_ra), .DATA_OUT(a_dout),
    .DATA_OUT_VALID(a_valid), .ADDR_ERR(a_err));

  memory_param #(.DATA_W(32), .DEPTH(200), .ADDR_W(8), .READ_REG(1), .INIT_WORD(32'hDEADBEEF)) u_dut_b (
    .CLK(clk), .RESET(b_rst), .READY(b_ready), .WRITE_ENABLE(b_we), .ADDRESS_WRITE(b_wa),
    .DATA_IN(b_din), .BYTE_EN(b_be), .RD_EN(b_rd), .ADDRESS_READ(b_ra), .DATA_OUT(b_dout),
    .DATA_OUT_VALID(b_valid), .ADDR_ERR(b_err));

  memory_param #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .READ_REG(0), .INIT_WORD(32'h0)) u_dut_c (
    .CLK(clk), .RESET(c_rst), .READY(c_ready), .WRITE_ENABLE(c_we), .ADDRESS_WRITE(c_wa),
    .DATA_IN(c_din), .BYTE_EN(c_be), .RD_EN(c_rd), .ADDRESS_READ(c_ra), .DATA_OUT(c_dout),
    .DATA_OUT_VALID(c_valid), .ADDR_ERR(c_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait never completes.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic a_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    a_we = 1'b1; a_wa = addr; a_din = data; a_be = be;
    @(negedge clk);
    a_we = 1'b0;
  endtask

  task automatic a_read(input logic [7:0] addr);
    a_rd = 1'b1; a_ra = addr;
    @(negedge clk);
    a_rd = 1'b0;
  endtask

  task automatic b_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    b_we = 1'b1; b_wa = addr; b_din = data; b_be = be;
    @(negedge clk);
    b_we = 1'b0;
  endtask

  task automatic b_read(input logic [7:0] addr);
    b_rd = 1'b1; b_ra = addr;
    @(negedge clk);
    b_rd = 1'b0;
  endtask

  // Edges from reset release (at a negedge) until READY of instance a is seen.
  task automatic a_wait_ready(output int n, inout int quiet_bad);
    n = 0;
    while (!a_ready && n < 400) begin
      @(negedge clk);
      n++;
      if (!a_ready && (a_valid || a_err)) quiet_bad++;
    end
  endtask

  initial begin
    int na, nb, nc, bad, quiet_bad;
    na = 0; nb = 0; nc = 0; bad = 0; quiet_bad = 0;

    a_rst = 1'b1; a_we = 1'b0; a_rd = 1'b0; a_wa = '0; a_ra = '0; a_din = '0; a_be = '0;
    b_rst = 1'b1; b_we = 1'b0; b_rd = 1'b0; b_wa = '0; b_ra = '0; b_din = '0; b_be = '0;
    c_rst = 1'b1; c_we = 1'b0; c_rd = 1'b0; c_wa = '0; c_ra = '0; c_din = '0; c_be = '0;

    repeat (2) @(negedge clk);
    check("rst_a_ready", a_ready, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_err",   a_err,   0);
    check("rst_a_dout",  a_dout,  0);
    check("rst_b_ready", b_ready, 0);
    check("rst_c_ready", c_ready, 0);
    check("rst_c_valid", c_valid, 0);

    // Release all resets; hammer requests during INIT that must be ignored.
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_we = 1'b1; a_wa = 8'd3; a_din = 32'hFFFFFFFF; a_be = 4'hF; a_rd = 1'b1; a_ra = 8'd3;
    b_we = 1'b1; b_wa = 8'd210; b_din = 32'h12345678; b_be = 4'hF; b_rd = 1'b1; b_ra = 8'd250;
    c_we = 1'b1; c_wa = 4'd1; c_din = 32'hFFFFFFFF; c_be = 4'hF;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (a_ready && na == 0) begin na = k; a_we = 1'b0; a_rd = 1'b0; end
      if (b_ready && nb == 0) begin nb = k; b_we = 1'b0; b_rd = 1'b0; end
      if (c_ready && nc == 0) begin nc = k; c_we = 1'b0; end
      if (!a_ready && (a_valid || a_err)) quiet_bad++;
      if (!b_ready && (b_valid || b_err)) quiet_bad++;
      if (!c_ready && (c_valid || c_err)) quiet_bad++;
      if (na != 0 && nb != 0 && nc != 0) break;
    end
    check("ready_lat_a", na, 256);
    check("ready_lat_b", nb, 200);
    check("ready_lat_c", nc, 12);
    check("init_quiet", quiet_bad, 0);
    check("init_a_err", a_err, 0);
    check("init_b_err", b_err, 0);

    // Every word of a reads back as INIT_WORD (0), back-to-back reads.
    for (int i = 0; i < 256; i++) begin
      a_read(8'(i));
      if (a_dout !== 32'h0 || a_valid !== 1'b1) bad++;
    end
    check("sweep_zero_a", bad, 0);
    check("sweep_err_a", a_err, 0);

    // Full-word write then registered read with latency 1.
    a_write(8'd11, 32'h55555555, 4'hF);
    a_read(8'd11);
    check("rd11_data",  a_dout,  32'h55555555);
    check("rd11_valid", a_valid, 1);
    @(negedge clk);
    check("rd_idle_valid", a_valid, 0);
    check("rd_idle_hold",  a_dout,  32'h55555555);

    // Byte merge with same-edge read of the written address (write-first).
    a_write(8'd5, 32'h11223344, 4'hF);
    a_we = 1'b1; a_wa = 8'd5; a_din = 32'hAABBCCDD; a_be = 4'b0101;
    a_rd = 1'b1; a_ra = 8'd5;
    @(negedge clk);
    a_we = 1'b0; a_rd = 1'b0;
    check("merge_rdw",   a_dout,  32'h11BB33DD);
    check("merge_valid", a_valid, 1);
    a_write(8'd5, 32'hFFFFFFFF, 4'h0);
    a_read(8'd5);
    check("be_zero_nochg", a_dout, 32'h11BB33DD);

    // Independent ports: write 20 while reading 11 in the same cycle.
    a_we = 1'b1; a_wa = 8'd20; a_din = 32'h12345678; a_be = 4'hF;
    a_rd = 1'b1; a_ra = 8'd11;
    @(negedge clk);
    a_we = 1'b0; a_rd = 1'b0;
    check("dual_rd11", a_dout, 32'h55555555);
    a_read(8'd20);
    check("dual_rd20", a_dout, 32'h12345678);
    a_read(8'd255);
    check("rd_last_a", a_dout, 32'h0);

    // Reset pulse, then a second reset at init index 100; writes during INIT ignored.
    a_rst = 1'b1;
    @(negedge clk);
    check("rst2_ready", a_ready, 0);
    check("rst2_dout",  a_dout,  0);
    a_rst = 1'b0;
    a_we = 1'b1; a_wa = 8'd200; a_din = 32'hCAFEF00D; a_be = 4'hF; a_rd = 1'b1; a_ra = 8'd9;
    quiet_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (a_ready || a_valid || a_err) quiet_bad++;
    end
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    a_wait_ready(na, quiet_bad);
    a_we = 1'b0; a_rd = 1'b0;
    check("midsweep_lat", na, 256);
    check("midsweep_quiet", quiet_bad, 0);
    a_read(8'd11);
    check("midsweep_rd11", a_dout, 32'h0);
    a_read(8'd200);
    check("midsweep_rd200", a_dout, 32'h0);
    a_read(8'd5);
    check("midsweep_rd5", a_dout, 32'h0);

    // Instance b: boundary in-range reads, then out-of-range accesses.
    b_read(8'd199);
    check("b_rd199", b_dout, 32'hDEADBEEF);
    check("b_err_clean", b_err, 0);
    b_read(8'd0);
    check("b_rd0", b_dout, 32'hDEADBEEF);
    b_write(8'd210, 32'hFFFFFFFF, 4'hF);
    check("b_err_wr", b_err, 1);
    b_read(8'd199);
    check("b_rd199_after", b_dout, 32'hDEADBEEF);
    b_write(8'd7, 32'h01020304, 4'hF);
    b_read(8'd210);
    check("b_oor_data",  b_dout,  32'h0);
    check("b_oor_valid", b_valid, 1);
    b_read(8'd7);
    check("b_rd7", b_dout, 32'h01020304);
    check("b_err_sticky", b_err, 1);
    b_rst = 1'b1;
    @(negedge clk);
    check("b_err_rst", b_err, 0);
    b_rst = 1'b0;

    // Instance c: combinational read, visible only after the write edge.
    check("c_valid_run", c_valid, 1);
    check("c_rd0_init", c_dout, 32'h0);
    c_we = 1'b1; c_wa = 4'd0; c_din = 32'h80400002; c_be = 4'hF;
    #1;
    check("c_before_edge", c_dout, 32'h0);
    @(negedge clk);
    c_we = 1'b0;
    check("c_after_edge", c_dout, 32'h80400002);
    c_we = 1'b1; c_wa = 4'd0; c_din = 32'hFFFFFFFF; c_be = 4'b1000;
    @(negedge clk);
    c_we = 1'b0;
    check("c_byte_merge", c_dout, 32'hFF400002);
    check("c_valid_hold", c_valid, 1);
    check("c_err_clean", c_err, 0);
    c_ra = 4'd12;
    #1;
    check("c_oor_data", c_dout, 32'h0);
    check("c_err_pre", c_err, 0);
    @(negedge clk);
    c_ra = 4'd0;
    check("c_err_set", c_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
